// File: rtl/cpu_decode_q_pkg.sv
// Shared moxie decode definitions: op codes, control-word layout and the
// opcode-class constants used by the decode queue and its opcode decoder.
package cpu_decode_q_pkg;

   // Form-1 op codes follow opcode-byte order so the decoder can index them directly.
   typedef enum logic [5:0] {
      OP_NOP = 6'd0, OP_LDI_L, OP_MOV, OP_JSRA, OP_RET, OP_ADD_L, OP_PUSH, OP_POP,
      OP_LDA_L, OP_STA_L, OP_LD_L, OP_ST_L, OP_LDO_L, OP_STO_L, OP_CMP,
      OP_JSR = 6'd15, OP_JMPA, OP_LDI_B, OP_LD_B, OP_LDA_B, OP_ST_B, OP_STA_B,
      OP_LDI_S, OP_LD_S, OP_LDA_S, OP_ST_S, OP_STA_S, OP_JMP, OP_AND, OP_LSHR,
      OP_ASHL, OP_SUB_L, OP_NEG, OP_OR, OP_NOT, OP_ASHR, OP_XOR, OP_MUL_L, OP_SWI,
      OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L, OP_BRK, OP_LDO_B, OP_STO_B,
      OP_LDO_S, OP_STO_S,
      OP_INC = 6'd48, OP_DEC, OP_GSR, OP_SSR,
      OP_BEQ = 6'd52, OP_BNE, OP_BLT, OP_BGT, OP_BLTU, OP_BGTU, OP_BGE, OP_BLE,
      OP_BGEU, OP_BLEU,
      OP_BAD = 6'd63
   } op_e;

   localparam int unsigned PCB_WIDTH   = 6;
   localparam int unsigned PCB_LONG    = 0;
   localparam int unsigned PCB_REGWR   = 1;
   localparam int unsigned PCB_MEMRD   = 2;
   localparam int unsigned PCB_MEMWR   = 3;
   localparam int unsigned PCB_CTRL    = 4;
   localparam int unsigned PCB_ILLEGAL = 5;

   localparam logic [7:0] ILL0_LO = 8'h0F;
   localparam logic [7:0] ILL0_HI = 8'h18;
   localparam logic [7:0] ILL1_LO = 8'h3A;
   localparam logic [7:0] ILL1_HI = 8'h7F;
   localparam logic [7:0] ILL2_LO = 8'hE8;
   localparam logic [7:0] ILL2_HI = 8'hFF;
   localparam logic [7:0] F1_GAP  = 8'd10;

   function automatic logic is_illegal(input logic [7:0] b);
      return b inside {[ILL0_LO:ILL0_HI], [ILL1_LO:ILL1_HI], [ILL2_LO:ILL2_HI]};
   endfunction

   function automatic logic is_long(input logic [7:0] b);
      return b inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B,
                       8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, [8'h36:8'h39]};
   endfunction

   function automatic logic [PCB_WIDTH-1:0] microcode(input logic [7:0] b);
      logic [PCB_WIDTH-1:0] w;
      w = '0;
      w[PCB_LONG]    = is_long(b);
      w[PCB_ILLEGAL] = is_illegal(b);
      w[PCB_REGWR]   = b inside {8'h01, 8'h02, 8'h05, 8'h07, 8'h08, 8'h0A, 8'h0C,
                                 [8'h1B:8'h1D], [8'h20:8'h22], [8'h26:8'h2F],
                                 [8'h31:8'h34], 8'h36, 8'h38, [8'h80:8'hAF]};
      w[PCB_MEMRD]   = b inside {8'h04, 8'h07, 8'h08, 8'h0A, 8'h0C, 8'h1C, 8'h1D,
                                 8'h21, 8'h22, 8'h36, 8'h38};
      w[PCB_MEMWR]   = b inside {8'h03, 8'h06, 8'h09, 8'h0B, 8'h0D, 8'h19, 8'h1E,
                                 8'h1F, 8'h23, 8'h24, 8'h37, 8'h39};
      w[PCB_CTRL]    = b inside {8'h03, 8'h04, 8'h19, 8'h1A, 8'h25, 8'h30, 8'h35,
                                 [8'hC0:8'hE7]};
      return w;
   endfunction

endpackage

// File: rtl/cpu_decode_q_opdecode.sv
// Combinational moxie opcode decoder: op code, register indices, resolved
// operand (long immediate, inc/dec immediate or branch target) and illegal flag.
module cpu_opdecode
   import cpu_decode_q_pkg::*;
#(
   parameter int unsigned PCW = 32
) (
   input  logic [15:0]    opcode,
   input  logic [31:0]    operand,
   input  logic [PCW-1:0] pc,
   output logic [5:0]     op,
   output logic [3:0]     ri_a,
   output logic [3:0]     ri_b,
   output logic [31:0]    res_operand,
   output logic           illegal
);

   logic [7:0]        b;
   logic signed [10:0] disp;
   logic [PCW-1:0]    target;
   op_e               opv;

   assign b      = opcode[15:8];
   assign disp   = {opcode[9:0], 1'b0};
   assign target = pc + PCW'(2) + PCW'(disp);

   always_comb begin
      ri_a        = '0;
      ri_b        = '0;
      res_operand = '0;
      opv         = OP_BAD;
      illegal     = is_illegal(b);
      if (!opcode[15]) begin
         ri_a = opcode[7:4];
         ri_b = opcode[3:0];
      end else if (!opcode[14]) begin
         ri_a = opcode[11:8];
         ri_b = opcode[3:0];
      end
      // Form-1 bytes above the 0x0F-0x18 hole sit F1_GAP positions lower in op_e.
      if (!illegal) begin
         if (!opcode[15])
            opv = op_e'((b < ILL0_LO) ? 6'(b) : 6'(b - F1_GAP));
         else if (!opcode[14])
            opv = op_e'(6'(OP_INC) + 6'(opcode[13:12]));
         else
            opv = op_e'(6'(OP_BEQ) + 6'(opcode[13:10]));
      end
      if (is_long(b))
         res_operand = operand;
      else if (opv == OP_INC || opv == OP_DEC)
         res_operand = {24'h0, opcode[7:0]};
      else if (opcode[15:14] == 2'b11 && !illegal)
         res_operand = 32'(target);
   end

   assign op = opv;

endmodule

// File: rtl/cpu_decode_q.sv
// Moxie decode stage: DEPTH-entry instruction queue between fetch and decode,
// feeding a registered output stage that holds under downstream stall.
module cpu_decode_q
   import cpu_decode_q_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PCW   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  stall_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [15:0]           opcode_i,
   input  logic [31:0]           operand_i,
   input  logic [PCW-1:0]        PC_i,
   output logic                  valid_o,
   output logic [5:0]            op_o,
   output logic [3:0]            riA_o,
   output logic [3:0]            riB_o,
   output logic [3:0]            register_write_index_o,
   output logic [31:0]           operand_o,
   output logic [PCW-1:0]        PC_o,
   output logic                  illegal_o,
   output logic [PCB_WIDTH-1:0]  pipeline_control_bits_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      logic [PCW-1:0] pc;
      logic [15:0]    opcode;
      logic [31:0]    operand;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   logic [5:0]    dec_op;
   logic [3:0]    dec_ra;
   logic [3:0]    dec_rb;
   logic [31:0]   dec_operand;
   logic          dec_illegal;

   assign ready_o                = (count != (AW+1)'(DEPTH));
   assign push                   = valid_i && ready_o && !flush_i;
   assign pop                    = !stall_i && !flush_i && (count != '0);
   assign head                   = mem[rd_ptr];
   assign count_o                = count;
   assign register_write_index_o = riA_o;

   always_ff @(posedge clk_i) begin
      if (push && !rst_i)
         mem[wr_ptr] <= '{pc: PC_i, opcode: opcode_i, operand: operand_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   cpu_opdecode #(.PCW(PCW)) u_opdecode (
      .opcode      (head.opcode),
      .operand     (head.operand),
      .pc          (head.pc),
      .op          (dec_op),
      .ri_a        (dec_ra),
      .ri_b        (dec_rb),
      .res_operand (dec_operand),
      .illegal     (dec_illegal)
   );

   // Flush clears only the validity-related outputs; the datapath fields hold.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o                 <= 1'b0;
         op_o                    <= OP_NOP;
         riA_o                   <= '0;
         riB_o                   <= '0;
         operand_o               <= '0;
         PC_o                    <= '0;
         illegal_o               <= 1'b0;
         pipeline_control_bits_o <= '0;
      end else if (flush_i) begin
         valid_o   <= 1'b0;
         op_o      <= OP_NOP;
         illegal_o <= 1'b0;
      end else if (!stall_i) begin
         if (pop) begin
            valid_o                 <= 1'b1;
            op_o                    <= dec_op;
            riA_o                   <= dec_ra;
            riB_o                   <= dec_rb;
            operand_o               <= dec_operand;
            PC_o                    <= head.pc;
            illegal_o               <= dec_illegal;
            pipeline_control_bits_o <= microcode(head.opcode[15:8]);
         end else begin
            valid_o <= 1'b0;
            op_o    <= OP_NOP;
         end
      end
   end

endmodule

// File: tb/tb_cpu_decode_q.sv
// Scoreboard bench for cpu_decode_q: stimulus queues expected decodes, a
// negedge monitor models the queue and compares every output each cycle.
module tb_cpu_decode_q;
   import cpu_decode_q_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned PCW   = 32;

   logic                  clk = 1'b0;
   logic                  rst_i, flush_i, stall_i, valid_i;
   logic                  ready_o;
   logic [15:0]           opcode_i;
   logic [31:0]           operand_i;
   logic [PCW-1:0]        PC_i;
   logic                  valid_o;
   logic [5:0]            op_o;
   logic [3:0]            riA_o, riB_o, register_write_index_o;
   logic [31:0]           operand_o;
   logic [PCW-1:0]        PC_o;
   logic                  illegal_o;
   logic [PCB_WIDTH-1:0]  pipeline_control_bits_o;
   logic [$clog2(DEPTH):0] count_o;

   cpu_decode_q #(.DEPTH(DEPTH), .PCW(PCW)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
      .valid_i(valid_i), .ready_o(ready_o), .opcode_i(opcode_i),
      .operand_i(operand_i), .PC_i(PC_i), .valid_o(valid_o), .op_o(op_o),
      .riA_o(riA_o), .riB_o(riB_o),
      .register_write_index_o(register_write_index_o),
      .operand_o(operand_o), .PC_o(PC_o), .illegal_o(illegal_o),
      .pipeline_control_bits_o(pipeline_control_bits_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                 valid;
      logic [5:0]           op;
      logic [3:0]           ra, rb;
      logic [31:0]          opd;
      logic [31:0]          pc;
      logic                 ill;
      logic [PCB_WIDTH-1:0] pcb;
   } out_t;

   localparam op_e F1 [48] = '{
      OP_NOP, OP_LDI_L, OP_MOV, OP_JSRA, OP_RET, OP_ADD_L, OP_PUSH, OP_POP,
      OP_LDA_L, OP_STA_L, OP_LD_L, OP_ST_L, OP_LDO_L, OP_STO_L, OP_CMP,
      OP_JSR, OP_JMPA, OP_LDI_B, OP_LD_B, OP_LDA_B, OP_ST_B, OP_STA_B,
      OP_LDI_S, OP_LD_S, OP_LDA_S, OP_ST_S, OP_STA_S, OP_JMP, OP_AND, OP_LSHR,
      OP_ASHL, OP_SUB_L, OP_NEG, OP_OR, OP_NOT, OP_ASHR, OP_XOR, OP_MUL_L,
      OP_SWI, OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L, OP_BRK, OP_LDO_B,
      OP_STO_B, OP_LDO_S, OP_STO_S};
   localparam op_e F2 [4]  = '{OP_INC, OP_DEC, OP_GSR, OP_SSR};
   localparam op_e BR [10] = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BLTU,
                               OP_BGTU, OP_BGE, OP_BLE, OP_BGEU, OP_BLEU};

   out_t issue_q[$];
   out_t m_fifo[$];
   out_t m_out;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic out_t reset_out();
      out_t r;
      r.valid = 1'b0; r.op = OP_NOP; r.ra = '0; r.rb = '0;
      r.opd = '0; r.pc = '0; r.ill = 1'b0; r.pcb = '0;
      return r;
   endfunction

   function automatic out_t ref_decode(input logic [15:0] opc, input logic [31:0] opd,
                                       input logic [31:0] pc);
      out_t       r;
      logic [7:0] b;
      int         d;
      b = opc[15:8];
      r = reset_out();
      r.valid = 1'b1;
      r.pc    = pc;
      r.pcb   = microcode(b);
      r.ill   = (b >= 8'h0F && b <= 8'h18) || (b >= 8'h3A && b <= 8'h7F) || (b >= 8'hE8);
      if (b < 8'h80) begin
         r.ra = opc[7:4]; r.rb = opc[3:0];
      end else if (b < 8'hC0) begin
         r.ra = opc[11:8]; r.rb = opc[3:0];
      end
      if (r.ill)            r.op = OP_BAD;
      else if (b < 8'h19)   r.op = F1[int'(b)];
      else if (b < 8'h80)   r.op = F1[int'(b) - 10];
      else if (b < 8'hC0)   r.op = F2[(int'(b) - 128) / 16];
      else                  r.op = BR[(int'(b) - 192) / 4];
      if (b inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
                    8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39})
         r.opd = opd;
      else if (b >= 8'h80 && b < 8'hA0)
         r.opd = {24'h0, opc[7:0]};
      else if (b >= 8'hC0 && !r.ill) begin
         d = int'(opc[9:0]);
         if (d >= 512) d = d - 1024;
         r.opd = 32'(longint'(pc) + 64'sd2 + 64'(2 * d));
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: compare outputs produced by the last edge, then advance the model.
   always @(negedge clk) begin
      out_t rec;
      bit   have;
      bit   do_push;
      chk("count",   64'(count_o), 64'(m_fifo.size()));
      chk("ready",   64'(ready_o), 64'(m_fifo.size() != DEPTH));
      chk("valid",   64'(valid_o), 64'(m_out.valid));
      chk("op",      64'(op_o), 64'(m_out.op));
      chk("riA",     64'(riA_o), 64'(m_out.ra));
      chk("riB",     64'(riB_o), 64'(m_out.rb));
      chk("rwi",     64'(register_write_index_o), 64'(m_out.ra));
      chk("operand", 64'(operand_o), 64'(m_out.opd));
      chk("pc",      64'(PC_o), 64'(m_out.pc));
      chk("illegal", 64'(illegal_o), 64'(m_out.ill));
      chk("pcb",     64'(pipeline_control_bits_o), 64'(m_out.pcb));
      have = 1'b0;
      rec  = reset_out();
      if (valid_i === 1'b1) begin
         if (issue_q.size() == 0) chk("issue_q_empty", 64'd1, 64'd0);
         else begin rec = issue_q.pop_front(); have = 1'b1; end
      end
      if (rst_i) begin
         m_fifo.delete();
         m_out = reset_out();
      end else if (flush_i) begin
         m_fifo.delete();
         m_out.valid = 1'b0; m_out.op = OP_NOP; m_out.ill = 1'b0;
      end else begin
         do_push = have && (m_fifo.size() < DEPTH);
         if (!stall_i) begin
            if (m_fifo.size() > 0) m_out = m_fifo.pop_front();
            else begin m_out.valid = 1'b0; m_out.op = OP_NOP; end
         end
         if (do_push) m_fifo.push_back(rec);
      end
   end

   task automatic cyc(input bit v, input logic [15:0] opc, input logic [31:0] opd,
                      input logic [31:0] pc, input bit st, input bit fl, input bit rs,
                      output bit acc);
      valid_i = v; opcode_i = opc; operand_i = opd; PC_i = pc;
      stall_i = st; flush_i = fl; rst_i = rs;
      if (v) issue_q.push_back(ref_decode(opc, opd, pc));
      acc = v && ready_o && !fl && !rs;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int k = 0; k < n; k++) cyc(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, a);
   endtask

   task automatic send(input logic [15:0] opc, input logic [31:0] opd, input logic [31:0] pc);
      bit acc;
      int tries;
      tries = 0;
      do begin
         cyc(1'b1, opc, opd, pc, 1'b0, 1'b0, 1'b0, acc);
         tries++;
      end while (!acc && tries < 16);
      if (!acc) chk("send_timeout", 64'd1, 64'd0);
   endtask

   task automatic fill_stalled();
      bit a;
      cyc(1'b1, 16'h0211, 32'h1111_0000, 32'h200, 1'b1, 1'b0, 1'b0, a);
      cyc(1'b1, 16'h0522, 32'h2222_0000, 32'h202, 1'b1, 1'b0, 1'b0, a);
      chk("fill_count", 64'(count_o), 64'(DEPTH));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          a;
      bit          v, st, fl, rs;
      logic [15:0] opc;
      logic [31:0] opd, pc;
      m_out = reset_out();
      rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
      opcode_i = '0; operand_i = '0; PC_i = '0;
      @(posedge clk); #1;
      cyc(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, a);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_op",    64'(op_o), 64'(OP_NOP));

      send(16'h0123, 32'hDEAD_BEEF, 32'h100); idle(1);
      chk("ldi_valid",   64'(valid_o), 64'd1);
      chk("ldi_op",      64'(op_o), 64'(OP_LDI_L));
      chk("ldi_riA",     64'(riA_o), 64'd2);
      chk("ldi_riB",     64'(riB_o), 64'd3);
      chk("ldi_operand", 64'(operand_o), 64'hDEAD_BEEF);
      chk("ldi_pc",      64'(PC_o), 64'h100);

      send(16'h83F5, 32'h1234_5678, 32'h104); idle(1);
      chk("inc_op", 64'(op_o), 64'(OP_INC));
      chk("inc_riA", 64'(riA_o), 64'd3);
      chk("inc_operand", 64'(operand_o), 64'hF5);

      send(16'hC3FF, 32'h0, 32'h1000); idle(1);
      chk("beq_op", 64'(op_o), 64'(OP_BEQ));
      chk("beq_back", 64'(operand_o), 64'h1000);
      send(16'hC001, 32'h0, 32'h1000); idle(1);
      chk("beq_fwd", 64'(operand_o), 64'h1004);
      send(16'hE401, 32'h0, 32'hFFFF_FFFE); idle(1);
      chk("bleu_op", 64'(op_o), 64'(OP_BLEU));
      chk("br_wrap", 64'(operand_o), 64'h2);

      send(16'h1000, 32'hFFFF_FFFF, 32'h300); idle(1);
      chk("ill0_flag", 64'(illegal_o), 64'd1);
      chk("ill0_op",   64'(op_o), 64'(OP_BAD));
      send(16'hE800, 32'hFFFF_FFFF, 32'h302); idle(1);
      chk("ill1_flag", 64'(illegal_o), 64'd1);
      chk("ill1_op",   64'(op_o), 64'(OP_BAD));

      // Stall with a full queue; the third instruction waits for space.
      cyc(1'b1, 16'h0521, 32'h0, 32'h400, 1'b1, 1'b0, 1'b0, a);
      cyc(1'b1, 16'h2634, 32'h0, 32'h402, 1'b1, 1'b0, 1'b0, a);
      chk("full_count", 64'(count_o), 64'd2);
      chk("full_ready", 64'(ready_o), 64'd0);
      cyc(1'b1, 16'h0A45, 32'h0, 32'h404, 1'b1, 1'b0, 1'b0, a);
      chk("full_count_held", 64'(count_o), 64'd2);
      send(16'h0A45, 32'h0, 32'h404);
      idle(4);

      for (int i = 0; i < 600; i++) begin
         opc = 16'($urandom);
         opd = $urandom;
         pc  = $urandom;
         v   = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 40) == 0);
         rs  = ($urandom_range(0, 90) == 0);
         cyc(v, opc, opd, pc, st, fl, rs, a);
      end
      idle(4);

      fill_stalled();
      cyc(1'b1, 16'h0633, 32'h0, 32'h500, 1'b1, 1'b1, 1'b0, a);
      chk("flush_count", 64'(count_o), 64'd0);
      chk("flush_valid", 64'(valid_o), 64'd0);
      chk("flush_op",    64'(op_o), 64'(OP_NOP));
      chk("flush_ready", 64'(ready_o), 64'd1);
      idle(2);

      fill_stalled();
      cyc(1'b1, 16'h0633, 32'h0, 32'h500, 1'b0, 1'b0, 1'b1, a);
      chk("rst_mid_count", 64'(count_o), 64'd0);
      chk("rst_mid_valid", 64'(valid_o), 64'd0);
      chk("rst_mid_op",    64'(op_o), 64'(OP_NOP));
      chk("rst_mid_pc",    64'(PC_o), 64'd0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
